// File: rtl/apb4_master_bridge_pkg.sv
// Shared types and bus widths for the APB4 master bridge.
// Widths are configured here; the interface and the bridge both take them from this package.
package apb4_master_bridge_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;
  localparam int unsigned PROT_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [PROT_W-1:0]     prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
  } apb_rsp_t;

  // APB4 forbids active strobes on reads.
  function automatic logic [APB_STRB_W-1:0] bus_strb(input logic write,
                                                     input logic [APB_STRB_W-1:0] strb);
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/apb4_master_bridge_if.sv
// Command, response and APB4 signals of the master bridge.
// The bridge takes the master modport; the environment (controller + completer) the slave one.
interface apb4_master_bridge_if;
  import apb4_master_bridge_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [APB_ADDR_W-1:0] cmd_addr;
  logic [APB_DATA_W-1:0] cmd_wdata;
  logic [APB_STRB_W-1:0] cmd_strb;
  logic [PROT_W-1:0]     cmd_prot;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_slverr;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_STRB_W-1:0] PSTRB;
  logic [PROT_W-1:0]     PPROT;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

endinterface

// File: rtl/apb4_master_bridge_wdog.sv
// ACCESS wait-cycle counter for the APB4 master bridge.
// Only present when APB_MST_TIMEOUT_EN is defined.
`ifdef APB_MST_TIMEOUT_EN
module apb4_master_bridge_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit_hit_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // limit_hit_c flags the LIMIT-th wait cycle, so the bridge can end the transfer on it.
  assign limit_hit_c = (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !limit_hit_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/apb4_master_bridge.sv
// APB4 requester: valid/ready command in, one SETUP/ACCESS transfer at a time, single-entry response out.
// Define APB_MST_TIMEOUT_EN to terminate ACCESS with an error after TIMEOUT_CYCLES wait cycles.
module apb4_master_bridge
  import apb4_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                  PCLK,
  input logic                  PRESET,
  apb4_master_bridge_if.master bus
);

  state_t   state;
  apb_cmd_t cmd;
  apb_rsp_t rsp;
  logic     rsp_valid;
  logic     accept;
  logic     rsp_take;
  logic     timeout;

  assign cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata,
                 strb: bus.cmd_strb, prot: bus.cmd_prot};

  // A pending response blocks new commands unless it drains this same cycle.
  assign rsp_take      = rsp_valid && bus.rsp_ready;
  assign bus.cmd_ready = !PRESET && (state == IDLE) && (!rsp_valid || bus.rsp_ready);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_MST_TIMEOUT_EN
  logic limit_hit;

  apb4_master_bridge_wdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk        (PCLK),
    .rst        (PRESET),
    .clr        (accept),
    .inc        ((state == ACCESS) && !bus.PREADY),
    .limit_hit_c(limit_hit)
  );

  assign timeout = (state == ACCESS) && !bus.PREADY && limit_hit;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      bus.PSEL    <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      bus.PSTRB   <= '0;
      bus.PPROT   <= '0;
      rsp_valid   <= 1'b0;
      rsp         <= '0;
    end else begin
      if (rsp_take) begin
        rsp_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= SETUP;
            bus.PSEL    <= 1'b1;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= cmd.write;
            bus.PADDR   <= cmd.addr;
            bus.PWDATA  <= cmd.wdata;
            bus.PSTRB   <= bus_strb(cmd.write, cmd.strb);
            bus.PPROT   <= cmd.prot;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ACCESS: begin
          // PREADY on the limit cycle takes priority over the timeout.
          if (bus.PREADY || timeout) begin
            state       <= IDLE;
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp.rdata   <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : '0;
            rsp.slverr  <= bus.PREADY ? bus.PSLVERR : 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_rdata  = rsp.rdata;
  assign bus.rsp_slverr = rsp.slverr;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: directed scenarios plus randomized transfers
// against a word-memory reference model and a behavioural APB completer.
module tb_apb4_master_bridge;
  import apb4_master_bridge_pkg::*;

  localparam int unsigned TO = 16;

  logic pclk = 1'b0;
  logic prst;

  always #5 pclk = ~pclk;

  apb4_master_bridge_if bus ();

  apb4_master_bridge #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK  (pclk),
    .PRESET(prst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [16];
  logic [31:0] cpl_mem   [16];

  int          cur_wait = 0;
  logic        cur_err  = 1'b0;
  int          acc      = 0;

  logic        e_write;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_strb;
  logic [2:0]  e_prot;
  logic [31:0] e_rdata;
  logic        e_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Behavioural completer: ready after cur_wait ACCESS cycles, memory-backed reads/writes.
  initial begin : completer
    for (int i = 0; i < 16; i++) cpl_mem[i] = 32'h0;
    bus.PREADY  = 1'b0;
    bus.PRDATA  = 32'h0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (bus.PSEL && bus.PENABLE) begin
        if (acc >= cur_wait) begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = cur_err;
          if (bus.PWRITE) begin
            bus.PRDATA = $urandom;
            for (int b = 0; b < 4; b++)
              if (bus.PSTRB[b]) cpl_mem[bus.PADDR[5:2]][8*b +: 8] = bus.PWDATA[8*b +: 8];
          end else begin
            bus.PRDATA = cpl_mem[bus.PADDR[5:2]];
          end
        end else begin
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'b1;
          bus.PRDATA  = $urandom;
        end
        acc++;
      end else begin
        acc         = 0;
        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
      end
    end
  end

  // Offer a command and record what the bridge must produce for it.
  task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p, input int wt, input logic er);
    e_write  = w;
    e_addr   = a;
    e_wdata  = d;
    e_strb   = s;
    e_prot   = p;
    e_err    = er;
    cur_wait = wt;
    cur_err  = er;
    if (w) begin
      e_rdata = 32'h0;
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[a[5:2]] = (model_mem[a[5:2]] & ~(32'hFF << (8 * b)))
                                      | (((d >> (8 * b)) & 32'hFF) << (8 * b));
    end else begin
      e_rdata = model_mem[a[5:2]];
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
  endtask

  task automatic check_setup();
    chk("setup_psel",    64'(bus.PSEL),    64'(1'b1));
    chk("setup_penable", 64'(bus.PENABLE), 64'(1'b0));
    chk("setup_paddr",   64'(bus.PADDR),   64'(e_addr));
    chk("setup_pwrite",  64'(bus.PWRITE),  64'(e_write));
    chk("setup_pstrb",   64'(bus.PSTRB),   64'(e_write ? e_strb : 4'h0));
    chk("setup_pprot",   64'(bus.PPROT),   64'(e_prot));
    if (e_write) chk("setup_pwdata", 64'(bus.PWDATA), 64'(e_wdata));
  endtask

  task automatic accept();
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 64'(n < 50), 64'(1'b1));
    tick();
    bus.cmd_valid = 1'b0;
    check_setup();
  endtask

  // Wait for the response, checking address-phase stability along the way.
  task automatic wait_rsp(input int exp_lat);
    int n = 0;
    while (!bus.rsp_valid && n < 200) begin
      if (bus.PSEL) begin
        chk("stable_paddr",  64'(bus.PADDR),  64'(e_addr));
        chk("stable_pwrite", 64'(bus.PWRITE), 64'(e_write));
        chk("stable_pstrb",  64'(bus.PSTRB),  64'(e_write ? e_strb : 4'h0));
        chk("stable_pprot",  64'(bus.PPROT),  64'(e_prot));
      end
      tick();
      n++;
    end
    if (exp_lat >= 0) chk("rsp_latency", 64'(n), 64'(exp_lat));
    chk("rsp_valid",    64'(bus.rsp_valid),  64'(1'b1));
    chk("cpl_psel",     64'(bus.PSEL),       64'(1'b0));
    chk("cpl_penable",  64'(bus.PENABLE),    64'(1'b0));
    chk("rsp_rdata",    64'(bus.rsp_rdata),  64'(e_rdata));
    chk("rsp_slverr",   64'(bus.rsp_slverr), 64'(e_err));
  endtask

  task automatic drain(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("rsp_hold_valid", 64'(bus.rsp_valid), 64'(1'b1));
      chk("rsp_hold_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
      chk("blocked_ready",  64'(bus.cmd_ready), 64'(1'b0));
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("drain_ready", 64'(bus.cmd_ready), 64'(1'b1));
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_cleared", 64'(bus.rsp_valid), 64'(1'b0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
    int          wt;
    logic        er;
    int          dl;

    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    prst          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'h0;
    bus.cmd_prot  = 3'h0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #22;
    chk("rst_psel",      64'(bus.PSEL),       64'(1'b0));
    chk("rst_penable",   64'(bus.PENABLE),    64'(1'b0));
    chk("rst_pwrite",    64'(bus.PWRITE),     64'(1'b0));
    chk("rst_paddr",     64'(bus.PADDR),      64'(32'h0));
    chk("rst_pwdata",    64'(bus.PWDATA),     64'(32'h0));
    chk("rst_pstrb",     64'(bus.PSTRB),      64'(4'h0));
    chk("rst_pprot",     64'(bus.PPROT),      64'(3'h0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid),  64'(1'b0));
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata),  64'(32'h0));
    chk("rst_rsp_err",   64'(bus.rsp_slverr), 64'(1'b0));
    chk("rst_cmd_ready", 64'(bus.cmd_ready),  64'(1'b0));
    tick();
    prst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'(1'b1));

    // Zero-wait write
    set_cmd(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'h0, 0, 1'b0);
    accept();
    wait_rsp(2);
    drain(0);

    // Read with three wait states after seeding the location
    set_cmd(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 3'h1, 0, 1'b0);
    accept();
    wait_rsp(2);
    drain(1);
    set_cmd(1'b0, 32'h20, 32'h1234_5678, 4'hF, 3'h2, 3, 1'b0);
    accept();
    wait_rsp(5);
    drain(0);

    // Error at completion; wait-cycle PSLVERR must not leak
    set_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'h5, 2, 1'b1);
    accept();
    wait_rsp(4);
    drain(0);
    set_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'h0, 3, 1'b0);
    accept();
    wait_rsp(5);
    drain(0);

    // Pending response blocks the next command; accept on the drain cycle
    set_cmd(1'b1, 32'h08, 32'h0BAD_F00D, 4'h5, 3'h3, 1, 1'b0);
    accept();
    wait_rsp(3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blocked_ready", 64'(bus.cmd_ready), 64'(1'b0));
      chk("pending_valid", 64'(bus.rsp_valid), 64'(1'b1));
    end
    set_cmd(1'b0, 32'h08, 32'h0, 4'hF, 3'h4, 0, 1'b0);
    chk("still_blocked", 64'(bus.cmd_ready), 64'(1'b0));
    bus.rsp_ready = 1'b1;
    #1;
    chk("drain_accept_ready", 64'(bus.cmd_ready), 64'(1'b1));
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("drain_accept_cleared", 64'(bus.rsp_valid), 64'(1'b0));
    check_setup();
    wait_rsp(2);
    drain(0);

    // Reset pulse during ACCESS aborts without a response
    set_cmd(1'b0, 32'h30, 32'h0, 4'h0, 3'h0, 6, 1'b0);
    accept();
    tick();
    tick();
    chk("abort_in_access", 64'(bus.PENABLE), 64'(1'b1));
    prst = 1'b1;
    #1;
    chk("abort_psel",      64'(bus.PSEL),      64'(1'b0));
    chk("abort_penable",   64'(bus.PENABLE),   64'(1'b0));
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'(1'b0));
    tick();
    tick();
    prst = 1'b0;
    tick();
    chk("rel_cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
    chk("rel_paddr",     64'(bus.PADDR),     64'(32'h0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_rsp", 64'(bus.rsp_valid), 64'(1'b0));
    end
    set_cmd(1'b0, 32'h20, 32'h0, 4'h0, 3'h0, 1, 1'b0);
    accept();
    wait_rsp(3);
    drain(0);

    // Ready on the last permitted wait cycle completes normally
    set_cmd(1'b0, 32'h20, 32'h0, 4'h0, 3'h0, int'(TO) - 1, 1'b0);
    accept();
    wait_rsp(int'(TO) + 1);
    drain(0);

    // Completer that never responds
    set_cmd(1'b0, 32'h14, 32'h0, 4'h0, 3'h1, 100000, 1'b0);
`ifdef APB_MST_TIMEOUT_EN
    e_rdata = 32'h0;
    e_err   = 1'b1;
    accept();
    wait_rsp(int'(TO) + 1);
    drain(0);
`else
    accept();
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("hold_access", 64'(bus.PSEL && bus.PENABLE), 64'(1'b1));
      chk("hold_no_rsp", 64'(bus.rsp_valid),           64'(1'b0));
    end
    cur_wait = 0;
    wait_rsp(-1);
    drain(0);
`endif

    // Randomized transfers
    for (int k = 0; k < 40; k++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      p  = 3'($urandom_range(0, 7));
      wt = int'($urandom_range(0, 4));
      er = 1'($urandom_range(0, 1));
      dl = int'($urandom_range(0, 2));
      set_cmd(w, a, d, s, p, wt, er);
      accept();
      wait_rsp(wt + 2);
      drain(dl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
